// File: rtl/aer_event_driver_pkg.sv
// aer_event_driver_pkg: FSM state encoding and channel count shared by the AER event driver.
package aer_event_driver_pkg;
    localparam int CHANNELS = 8;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FIRE = 2'd1, ST_GAP = 2'd2} state_t;
endpackage

// File: rtl/aer_fifo.sv
// aer_fifo: power-of-two event buffer with wrap-bit pointers, flush and occupancy count.
module aer_fifo #(
    parameter int P_DEPTH = 4,
    parameter int P_WIDTH = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [P_WIDTH-1:0]         i_wdata,
    input  logic                       i_pop,
    output logic [P_WIDTH-1:0]         o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(P_DEPTH):0]   o_count
);
    localparam int AW = $clog2(P_DEPTH);
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic do_push, do_pop;
    always_comb begin
        do_push = i_push && !o_full && !i_flush;
        do_pop  = i_pop && !o_empty && !i_flush;
        wptr_d  = i_flush ? '0 : wptr_q + (AW+1)'(do_push);
        rptr_d  = i_flush ? '0 : rptr_q + (AW+1)'(do_pop);
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= i_wdata;
    end
    assign o_rdata = mem_q[rptr_q[AW-1:0]];
    assign o_count = wptr_q - rptr_q;
    assign o_empty = wptr_q == rptr_q;
    assign o_full  = o_count == (AW+1)'(P_DEPTH);
endmodule

// File: rtl/aer_event_driver.sv
// aer_event_driver: buffers AER addresses and replays them as one-hot single-cycle pulses
// with a programmable idle gap after each pulse.
module aer_event_driver
    import aer_event_driver_pkg::*;
#(
    parameter int P_ADDR_W     = 3,
    parameter int P_FIFO_DEPTH = 4,
    parameter int P_GAP_W      = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    input  logic [P_ADDR_W-1:0]             i_addr,
    output logic                            o_ready,
    input  logic [P_GAP_W-1:0]              i_gap,
    input  logic                            i_flush,
    output logic [CHANNELS:1]               o_event,
    output logic                            o_busy,
    output logic [$clog2(P_FIFO_DEPTH):0]   o_count
);
    state_t st_q, st_d;
    logic [P_GAP_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS:1] ev_q, ev_d, hot;
    logic rdy_q, full, empty, pop, push;
    logic [P_ADDR_W-1:0] rdata;
    assign o_ready = rdy_q && !full;
    assign push    = i_valid && o_ready;
    aer_fifo #(.P_DEPTH(P_FIFO_DEPTH), .P_WIDTH(P_ADDR_W)) u_fifo (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_push(push), .i_wdata(i_addr), .i_pop(pop),
        .o_rdata(rdata), .o_full(full), .o_empty(empty), .o_count(o_count)
    );
    always_comb begin
        hot   = CHANNELS'(1) << rdata;
        st_d  = st_q;
        cnt_d = cnt_q;
        ev_d  = '0;
        pop   = 1'b0;
        case (st_q)
            ST_IDLE: pop = !empty;
            ST_FIRE: if (i_gap != '0) begin
                st_d  = ST_GAP;
                cnt_d = i_gap - 1'b1;
            end else begin
                pop  = !empty;
                st_d = ST_IDLE;
            end
            ST_GAP: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else begin
                pop  = !empty;
                st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
        if (pop) begin
            st_d = ST_FIRE;
            ev_d = hot;
        end
        // flush wins over everything; a pulse already on o_event still finishes its cycle
        if (i_flush) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
            ev_d  = '0;
            pop   = 1'b0;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_q  <= ST_IDLE;
            cnt_q <= '0;
            ev_q  <= '0;
            rdy_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            ev_q  <= ev_d;
            rdy_q <= 1'b1;
        end
    end
    assign o_event = ev_q;
    assign o_busy  = (st_q != ST_IDLE) || !empty;
endmodule

// File: tb/tb_aer_event_driver.sv
// tb_aer_event_driver: directed vector table plus hand sequences for backpressure and async reset.
module tb_aer_event_driver;
    logic clk = 1'b0, rst = 1'b0, valid = 1'b0, flush = 1'b0;
    logic [2:0] addr = '0;
    logic [3:0] gap = '0;
    logic ready, busy;
    logic [8:1] ev;
    logic [2:0] cnt;
    logic [12:0] outs;
    int n_pass = 0, n_total = 0;

    assign outs = {ready, ev, busy, cnt};
    always #5 clk = ~clk;

    aer_event_driver dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_addr(addr), .o_ready(ready),
        .i_gap(gap), .i_flush(flush), .o_event(ev), .o_busy(busy), .o_count(cnt)
    );

    typedef struct {
        logic v;
        logic [2:0] a;
        logic [3:0] g;
        logic f;
        logic [12:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [2:0] a, logic [3:0] g, logic f,
                                logic r, logic [7:0] e, logic b, logic [2:0] c);
        vec_t t;
        t.v = v; t.a = a; t.g = g; t.f = f; t.exp = {r, e, b, c};
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input logic [2:0] a, input logic [3:0] g, input logic f);
        @(negedge clk);
        valid = v; addr = a; gap = g; flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_acc, peak, bad_ready, bad_hot, bad_gap, quiet_err, idx;
        logic will;
        int pulses[$];
        int pcyc[$];

        // single event
        tbl.push_back(mk(1,5,0,0, 1,8'h00,1,1));
        tbl.push_back(mk(0,0,0,0, 1,8'h20,1,0));
        tbl.push_back(mk(0,0,0,0, 1,8'h00,0,0));
        // back-to-back at full throughput
        tbl.push_back(mk(1,0,0,0, 1,8'h00,1,1));
        tbl.push_back(mk(1,1,0,0, 1,8'h01,1,1));
        tbl.push_back(mk(1,2,0,0, 1,8'h02,1,1));
        tbl.push_back(mk(1,3,0,0, 1,8'h04,1,1));
        tbl.push_back(mk(0,0,0,0, 1,8'h08,1,0));
        tbl.push_back(mk(0,0,0,0, 1,8'h00,0,0));
        // gap of 3, i_gap changed mid-gap
        tbl.push_back(mk(1,7,3,0, 1,8'h00,1,1));
        tbl.push_back(mk(1,6,3,0, 1,8'h80,1,1));
        tbl.push_back(mk(0,0,3,0, 1,8'h00,1,1));
        tbl.push_back(mk(0,0,0,0, 1,8'h00,1,1));
        tbl.push_back(mk(0,0,0,0, 1,8'h00,1,1));
        tbl.push_back(mk(0,0,3,0, 1,8'h40,1,0));
        tbl.push_back(mk(0,0,3,0, 1,8'h00,1,0));
        tbl.push_back(mk(0,0,3,0, 1,8'h00,1,0));
        tbl.push_back(mk(0,0,3,0, 1,8'h00,1,0));
        tbl.push_back(mk(0,0,3,0, 1,8'h00,0,0));
        // fill to 3, flush with simultaneous push
        tbl.push_back(mk(1,1,15,0, 1,8'h00,1,1));
        tbl.push_back(mk(1,2,15,0, 1,8'h02,1,1));
        tbl.push_back(mk(1,3,15,0, 1,8'h00,1,2));
        tbl.push_back(mk(1,4,15,0, 1,8'h00,1,3));
        tbl.push_back(mk(1,5,15,1, 1,8'h00,0,0));
        tbl.push_back(mk(0,0,15,0, 1,8'h00,0,0));
        tbl.push_back(mk(0,0,15,0, 1,8'h00,0,0));
        tbl.push_back(mk(0,0,15,0, 1,8'h00,0,0));
        tbl.push_back(mk(1,6,0,0, 1,8'h00,1,1));
        tbl.push_back(mk(0,0,0,0, 1,8'h40,1,0));
        tbl.push_back(mk(0,0,0,0, 1,8'h00,0,0));

        #1 rst = 1'b1;
        #11;
        chk("reset_outputs", outs, 13'h0);
        @(negedge clk) rst = 1'b0;
        #1 chk("ready_low_before_edge", ready, 1'b0);
        @(posedge clk); #1;
        chk("ready_rise", outs, {1'b1, 8'h00, 1'b0, 3'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].g, tbl[i].f);
            chk($sformatf("vec%0d", i), outs, tbl[i].exp);
        end

        // hold valid with gap 15 until full, then drain
        n_acc = 0; peak = 0; bad_ready = 0; bad_hot = 0;
        for (int c = 0; c < 400 && pulses.size() < 6; c++) begin
            @(negedge clk);
            flush = 1'b0; gap = 4'd15;
            valid = n_acc < 6;
            addr = 3'(n_acc);
            will = valid && ready;
            @(posedge clk); #1;
            if (will) n_acc++;
            if (int'(cnt) > peak) peak = int'(cnt);
            if (cnt == 3'd4 && ready) bad_ready++;
            if (c == 4) chk("full_stall", {ready, cnt}, {1'b0, 3'd4});
            if (ev != '0) begin
                if (!$onehot(ev)) bad_hot++;
                idx = 0;
                for (int b = 1; b <= 8; b++) if (ev[b]) idx = b - 1;
                pulses.push_back(idx);
                pcyc.push_back(c);
            end
        end
        valid = 1'b0;
        chk("accepted", n_acc, 6);
        chk("pulse_count", pulses.size(), 6);
        for (int i = 0; i < pulses.size(); i++) chk($sformatf("order%0d", i), pulses[i], i);
        bad_gap = 0;
        for (int i = 1; i < pcyc.size(); i++) if (pcyc[i] - pcyc[i-1] != 16) bad_gap++;
        chk("gap15_spacing", bad_gap, 0);
        chk("peak_count", peak, 4);
        chk("ready_when_full", bad_ready, 0);
        chk("onehot", bad_hot, 0);
        quiet_err = 0;
        for (int c = 0; c < 40 && busy; c++) begin
            drive(0, 0, 15, 0);
            if (ev != '0) quiet_err++;
        end
        chk("drain_idle", {busy, cnt, 8'(quiet_err)}, 12'h0);

        // async reset mid-gap with two events buffered
        drive(1, 1, 15, 0);
        drive(1, 2, 15, 0);
        chk("pre_reset_pulse", ev, 8'h02);
        drive(1, 3, 15, 0);
        drive(0, 0, 15, 0);
        chk("pre_reset_gap", {ev, busy, cnt}, {8'h00, 1'b1, 3'd2});
        #2 rst = 1'b1;
        #1 chk("async_reset", outs, 13'h0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        quiet_err = 0;
        for (int c = 0; c < 25; c++) begin
            drive(0, 0, 0, 0);
            if (ev != '0 || busy || cnt != '0) quiet_err++;
        end
        chk("quiet_after_reset", quiet_err, 0);
        drive(1, 4, 0, 0);
        chk("post_reset_push", outs, {1'b1, 8'h00, 1'b1, 3'd1});
        drive(0, 0, 0, 0);
        chk("post_reset_pulse", outs, {1'b1, 8'h10, 1'b1, 3'd0});
        drive(0, 0, 0, 0);
        chk("post_reset_idle", outs, {1'b1, 8'h00, 1'b0, 3'd0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/aer_event_driver.md
AER_EVENT_DRIVER -- requirements
Module: aer_event_driver

Interface
REQ-001 SHALL have parameter P_ADDR_W, default 3, meaning the input channel address width; the channel count is 2**P_ADDR_W = 8.
REQ-002 SHALL have parameter P_FIFO_DEPTH, default 4, meaning the event buffer depth in entries; it SHALL be a power of two and at least 2.
REQ-003 SHALL have parameter P_GAP_W, default 4, meaning the width of the inter-event gap count.
REQ-004 Port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port i_valid, input, 1 bit: an upstream event is present on i_addr.
REQ-007 Port i_addr, input, P_ADDR_W bits: the target synapse channel, 0..7.
REQ-008 Port o_ready, output, 1 bit: the block can accept an event this cycle.
REQ-009 Port i_gap, input, P_GAP_W bits: the number of idle cycles to insert after each emitted event.
REQ-010 Port i_flush, input, 1 bit: synchronous discard of all buffered events.
REQ-011 Port o_event, output, [8:1]: one-hot event pulses, wired to the neuron event input.
REQ-012 Port o_busy, output, 1 bit: the FSM is not IDLE or the FIFO is not empty.
REQ-013 Port o_count, output, clog2(P_FIFO_DEPTH)+1 bits: the current FIFO occupancy.

Function
REQ-014 An event SHALL be accepted on a rising edge where i_valid && o_ready.
REQ-015 o_ready SHALL be !full, registered-state derived only, with no combinational dependence on i_valid.
REQ-016 When the FIFO is full, o_ready SHALL be 0 even if a pop occurs in the same cycle; the FIFO SHALL never overflow or silently drop an event.
REQ-017 Events SHALL be emitted in acceptance order (FIFO).
REQ-018 FSM states SHALL be IDLE, FIRE and GAP.
REQ-019 IDLE: if the FIFO is non-empty, pop and go to FIRE; otherwise stay in IDLE.
REQ-020 FIRE: o_event[addr+1] SHALL be 1 for exactly one cycle and all other bits 0.
REQ-021 On leaving FIRE: if i_gap != 0, go to GAP with the counter loaded to i_gap-1; else if the FIFO is non-empty, pop and stay in FIRE; else go to IDLE.
REQ-022 GAP: o_event SHALL be 0; the counter decrements each cycle; at 0, pop and go to FIRE if the FIFO is non-empty, else go to IDLE.
REQ-023 i_gap SHALL be sampled on FIRE exit only; changes during GAP SHALL not affect the current gap.
REQ-024 o_event SHALL be registered; an event accepted at edge E0 into an empty FIFO with the FSM in IDLE SHALL drive o_event high from edge E1 to edge E2, i.e. 1-cycle latency.
REQ-025 With i_gap=0 and a continuously non-empty FIFO, o_event SHALL pulse on consecutive cycles, giving a throughput of 1 event per clock.
REQ-026 A push and a pop in the same cycle (FIFO not full) SHALL leave o_count unchanged.
REQ-027 Read and write pointers SHALL wrap modulo P_FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-028 i_flush SHALL clear the FIFO, force the FSM to IDLE and clear the gap counter at the next edge.
REQ-029 i_flush SHALL take precedence over a simultaneous push; that push SHALL be discarded.
REQ-030 An o_event pulse already registered when i_flush is sampled SHALL complete its single cycle; no further pulses SHALL follow.
REQ-031 o_event SHALL be all-zero in IDLE and GAP; more than one bit high is illegal.

Reset
REQ-032 While i_rst=1, all state SHALL clear immediately, without waiting for a clock: FIFO empty, FSM in IDLE, gap counter 0.
REQ-033 While i_rst=1, outputs SHALL be o_event=0, o_busy=0, o_count=0 and o_ready=0.
REQ-034 o_ready SHALL rise only on the first edge after i_rst deasserts.
REQ-035 A reset asserted mid-FIRE or mid-GAP SHALL abort the pulse or gap and drop all buffered events.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding constants (IDLE/FIRE/GAP) and the channel count constant (8).
REQ-037 The FIFO SHALL be a sub-module named aer_fifo with parameters for depth and width, push/pop ports, and full/empty/count outputs.
REQ-038 The FSM, gap counter and one-hot decoder SHALL reside in aer_event_driver.

Verification
REQ-039 Reset, then a single push of addr=5 with i_gap=0 -> o_event=8'b0010_0000 for exactly 1 cycle, 1 cycle after acceptance; then o_busy=0.
REQ-040 Push addrs 0,1,2,3 back-to-back with i_gap=0 -> o_event pulses bits 1,2,3,4 on 4 consecutive cycles, and o_count peaks at the expected value.
REQ-041 i_gap=3, push addrs 7 then 6 -> pulse on bit 8, 3 zero cycles, then pulse on bit 7.
REQ-042 Hold i_valid=1 with i_gap=15 until full -> o_ready=0 at o_count=4, no push lost, and all 5+ offered events emitted in order once accepted.
REQ-043 Fill the FIFO with 3 events, assert i_flush together with i_valid -> o_count=0 next cycle, no further pulses, and the simultaneous push discarded.
REQ-044 Assert i_rst asynchronously mid-GAP with 2 events buffered -> outputs zero before the next edge, and no pulses after release until a new push.
